// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store unit placed after the ALU. Turns the ALU result into a
//            word-aligned memory request with byte enables and lane-replicated
//            store data, stalls the core while the access is outstanding, and
//            sign/zero-extends load data for writeback. Illegal funct3,
//            misaligned accesses (optional) and memory timeouts end with err.
// Config   : `define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
//            Without it, halves use addr[1] only and words ignore addr[1:0].
// Params   : TIMEOUT_CYCLES - BUSY cycles without mem_ready before abort (1..255)
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            core_valid/core_we/funct3/addr/wdata - access request from core
//            stall, done, load_data, err          - status back to the core
//            mem_req/mem_we/mem_be/mem_addr/mem_wdata - registered memory request
//            mem_rdata, mem_ready                 - memory response
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_valid,
  input  logic        core_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Value of the wait counter on the last BUSY cycle allowed without mem_ready.
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  logic        legal_d;
  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_d;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Legality of the incoming request: stores only have sizes 0..2,
  // loads additionally have the unsigned byte/half forms.
  always_comb begin
    legal_d = 1'b0;
    if (core_we) begin
      legal_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      legal_d = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_d = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign_d = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata;
      end
    endcase
  end

  // Lane selection and extension of the returned word, using the latched
  // size and byte offset of the access in flight.
  always_comb begin
    rd_byte = mem_rdata[8*off_q +: 8];
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext_d = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ext_d = {{16{rd_half[15]}}, rd_half};
      3'b100:  ext_d = {24'd0, rd_byte};
      3'b101:  ext_d = {16'd0, rd_half};
      default: ext_d = mem_rdata;
    endcase
  end

  assign stall = core_valid & ~done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      load_data <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'd0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (core_valid) begin
            f3_q  <= funct3;
            off_q <= addr[1:0];
            cnt_q <= 8'd0;
            if (legal_d && !misalign_d) begin
              state_q   <= S_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= core_we;
              mem_be    <= be_d;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata_d;
            end else begin
              // Rejected without ever touching memory.
              state_q   <= S_DONE;
              done      <= 1'b1;
              err       <= 1'b1;
              load_data <= 32'd0;
            end
          end
        end
        S_BUSY: begin
          // mem_ready is tested first so it wins over a coincident timeout.
          if (mem_ready) begin
            state_q   <= S_DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b0;
            load_data <= mem_we ? 32'd0 : ext_d;
            cnt_q     <= 8'd0;
          end else if (cnt_q == C_TIMEOUT_LAST) begin
            state_q   <= S_DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            load_data <= 32'd0;
            cnt_q     <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          err     <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Self-checking bench for lsu_ctrl. A transaction-level model
//            predicts, for each access, the cycle of done, the request fields,
//            err and the extended load value; a negedge compare process checks
//            the DUT against it every cycle. Directed accesses with literal
//            expectations pin the model, then randomized accesses follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int T = 4;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        core_valid, core_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_we(core_we), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .load_data(load_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state for the access in flight.
  bit          chk_en = 1'b0;
  bit          in_txn = 1'b0;
  int          cyc    = 0;
  int          exp_lat;
  bit          exp_ok, exp_err, exp_we, exp_chk_ld;
  logic [31:0] exp_ld, exp_addr, exp_wd;
  logic [3:0]  exp_be;
  bit          e_req, e_done;

  typedef struct {
    bit          err;
    logic [31:0] ld;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          we;
    bit          saw_req;
    int          lat;
  } res_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic int m_off(input logic [2:0] f3, input logic [31:0] a);
    int s = m_size(f3);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    int s = m_size(f3);
    return TRAP_EN && ((a % s) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int s = m_size(f3);
    return 4'(((1 << s) - 1) << m_off(f3, a));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return (wd & 32'hFF) * 32'h01010101;
      2:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int s = m_size(f3);
    logic [31:0] v;
    v = rd >> (8 * m_off(f3, a));
    if (s < 4) begin
      v = v & ((32'd1 << (8 * s)) - 32'd1);
      if (!f3[2] && v[8*s-1]) v = v - (32'd1 << (8 * s));
    end
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      e_req  = in_txn && exp_ok && (cyc >= 1) && (cyc < exp_lat);
      e_done = in_txn && (cyc == exp_lat);
      chk("stall", {31'd0, stall}, {31'd0, core_valid && !e_done});
      chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      chk("done", {31'd0, done}, {31'd0, e_done});
      if (e_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (e_done) begin
        chk("err", {31'd0, err}, {31'd0, exp_err});
        if (exp_chk_ld) chk("load_data", load_data, exp_ld);
      end
    end
  end

  // ---------------- driver / memory responder ----------------
  // Called right after a rising edge with the DUT idle; returns in the done cycle.
  task automatic access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int waits,
                        input bit drop_valid, output res_t r);
    int busy_n = 0;
    bit seen   = 1'b0;
    r = '{default: '0};
    exp_ok  = m_legal(we, f3) && !m_misaligned(f3, a);
    exp_we  = we;
    exp_be  = m_be(f3, a);
    exp_addr = {a[31:2], 2'b00};
    exp_wd  = m_wdata(f3, wd);
    if (!exp_ok) begin
      exp_lat = 1; exp_err = 1'b1; exp_ld = 32'd0;
    end else if (waits >= T) begin
      exp_lat = T + 1; exp_err = 1'b1; exp_ld = 32'd0;
    end else begin
      exp_lat = 2 + waits; exp_err = 1'b0; exp_ld = m_load(f3, a, rd);
    end
    exp_chk_ld = !we || exp_err;
    core_valid = 1'b1; core_we = we; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'b0;
    cyc = 0; in_txn = 1'b1;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        seen = 1'b1; r.err = err; r.ld = load_data; r.lat = cyc;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!r.saw_req) begin
          r.saw_req = 1'b1; r.maddr = mem_addr; r.be = mem_be;
          r.wd = mem_wdata; r.we = mem_we;
        end
        mem_ready = (waits < T) && (busy_n == waits);
        mem_rdata = mem_ready ? rd : $urandom;
        busy_n++;
        if (drop_valid && busy_n == 1) core_valid = 1'b0;
      end else begin
        mem_ready = 1'b0;
      end
    end
    chk("done_within_bound", {31'd0, seen}, 32'd1);
  endtask

  // Leave the done cycle, then optionally idle for n cycles.
  task automatic gap(input int n);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_txn = 1'b0; core_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t        r;
    logic [2:0]  f3;
    logic [2:0]  legal_tab [5];
    legal_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1; core_valid = 1'b1; core_we = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd1);
    core_valid = 1'b0;
    #1;
    chk("rst_stall_low", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;

    // LW with two wait cycles.
    access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 2, 1'b0, r);
    chk("lw_ld", r.ld, 32'hDEADBEEF);
    chk("lw_err", {31'd0, r.err}, 32'd0);
    chk("lw_addr", r.maddr, 32'h100);
    chk("lw_be", {28'd0, r.be}, 32'hF);
    chk("lw_lat", r.lat, 32'd4);
    gap(0);
    // Lane selection / extension.
    access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF1234, 0, 1'b0, r);
    chk("lb_ld", r.ld, 32'hFFFFFF80);
    chk("lb_lat", r.lat, 32'd2);
    gap(1);
    access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF1234, 0, 1'b0, r);
    chk("lbu_ld", r.ld, 32'h00000080);
    gap(0);
    access(1'b0, 3'b001, 32'h102, 32'd0, 32'h80FF1234, 1, 1'b0, r);
    chk("lh_ld", r.ld, 32'hFFFF80FF);
    gap(2);
    // SH store.
    access(1'b1, 3'b001, 32'h106, 32'h0000ABCD, 32'd0, 1, 1'b0, r);
    chk("sh_we", {31'd0, r.we}, 32'd1);
    chk("sh_be", {28'd0, r.be}, 32'hC);
    chk("sh_addr", r.maddr, 32'h104);
    chk("sh_wdata", r.wd, 32'hABCDABCD);
    gap(0);
    // Misaligned LW.
    access(1'b0, 3'b010, 32'h102, 32'd0, 32'h12345678, 0, 1'b0, r);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, r.err}, 32'd1);
    chk("mis_lat", r.lat, 32'd1);
    chk("mis_no_req", {31'd0, r.saw_req}, 32'd0);
`else
    chk("mis_err", {31'd0, r.err}, 32'd0);
    chk("mis_addr", r.maddr, 32'h100);
    chk("mis_ld", r.ld, 32'h12345678);
`endif
    gap(0);
    // mem_ready on the same cycle the timeout would fire.
    access(1'b0, 3'b010, 32'h44, 32'd0, 32'hCAFEF00D, T - 1, 1'b0, r);
    chk("edge_err", {31'd0, r.err}, 32'd0);
    chk("edge_ld", r.ld, 32'hCAFEF00D);
    chk("edge_lat", r.lat, 32'd5);
    gap(0);
    // Timeout.
    access(1'b0, 3'b010, 32'h40, 32'd0, 32'd0, 99, 1'b0, r);
    chk("to_err", {31'd0, r.err}, 32'd1);
    chk("to_ld", r.ld, 32'd0);
    chk("to_lat", r.lat, 32'd5);
    gap(0);
    // Illegal funct3.
    access(1'b0, 3'b011, 32'h80, 32'd0, 32'd0, 0, 1'b0, r);
    chk("ill_ld_err", {31'd0, r.err}, 32'd1);
    chk("ill_ld_lat", r.lat, 32'd1);
    gap(0);
    access(1'b1, 3'b100, 32'h80, 32'h1, 32'd0, 0, 1'b0, r);
    chk("ill_st_err", {31'd0, r.err}, 32'd1);
    chk("ill_st_req", {31'd0, r.saw_req}, 32'd0);
    gap(0);

    // Reset during the second BUSY cycle.
    chk_en = 1'b0; in_txn = 1'b0;
    core_valid = 1'b1; core_we = 1'b0; funct3 = 3'b010; addr = 32'h200; mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rst_no_done", {31'd0, done}, 32'd0);
    rst = 1'b0; core_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle_done", {31'd0, done}, 32'd0);
    chk("rst_idle_req", {31'd0, mem_req}, 32'd0);
    chk_en = 1'b1;
    access(1'b0, 3'b010, 32'h300, 32'd0, 32'h0BADF00D, 1, 1'b0, r);
    chk("post_rst_ld", r.ld, 32'h0BADF00D);
    chk("post_rst_lat", r.lat, 32'd3);
    gap(0);

    // Randomized accesses.
    for (int k = 0; k < 300; k++) begin
      bit we;
      we = 1'($urandom % 2);
      if ($urandom % 10 == 0) f3 = 3'($urandom);
      else if (we)            f3 = 3'($urandom % 3);
      else                    f3 = legal_tab[$urandom % 5];
      access(we, f3, $urandom, $urandom, $urandom, $urandom_range(0, T + 1),
             ($urandom % 8) == 0, r);
      gap($urandom_range(0, 2));
    end

    in_txn = 1'b0; core_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting directly downstream of the ALU in the single-cycle RISC-V datapath. It takes the ALU `Result` as the effective address, runs a registered request/ready handshake with data memory, and generates byte enables and replicated store data. For loads it sign- or zero-extends the returned data for writeback. While a memory access is outstanding it stalls the core; it flags illegal, misaligned and timed-out accesses.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles `mem_req` stays high without `mem_ready` before the access aborts with an error (1..255).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `core_valid` input 1: a load or store is pending; held stable by the core until `done`.
- `core_we` input 1: 1 = store, 0 = load.
- `funct3` input 3: RISC-V access size and sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `addr` input 32: effective address, driven from the ALU `Result`.
- `wdata` input 32: store data (rs2).
- `stall` output 1: freezes the PC and register writes.
- `done` output 1: one-cycle pulse marking access completion.
- `load_data` output 32: extended load result, valid while `done` is high.
- `err` output 1: valid with `done`; illegal funct3, misaligned access or timeout.
- `mem_req` output 1: memory request.
- `mem_we` output 1: memory write.
- `mem_be` output 4: byte enables.
- `mem_addr` output 32: word address (`addr[31:2]`, 2'b00).
- `mem_wdata` output 32: lane-replicated store data.
- `mem_rdata` input 32: read data, valid with `mem_ready`.
- `mem_ready` input 1: memory accepts or completes the access this cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On `core_valid`, latch `core_we`, `funct3`, `addr` and `wdata`.
  - If the access is legal, go to BUSY.
  - If it is illegal or misaligned, go straight to DONE with `err`=1, and do not raise `mem_req`.
- BUSY:
  - `mem_req`=1 and the `mem_*` outputs come from the latched values.
  - On `mem_ready`, register the extended read data and go to DONE.
  - The timeout counter increments every BUSY cycle without `mem_ready`. When it reaches `TIMEOUT_CYCLES`, go to DONE with `err`=1 and `load_data`=0.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `stall` = `core_valid` & ~`done` (combinational).
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else raises `err`.
- Byte enables:
  - Byte: `mem_be` = 0001 << `addr[1:0]`.
  - Half: 0011 if `addr[1]`=0, 1100 if `addr[1]`=1.
  - Word: 1111.
  - Loads drive the same enables.
- Store data: byte is replicated ×4, half ×2, word is passed through.
- Load extension: select the addressed lane; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Boundary cases:
  - `mem_ready` in the same cycle the timeout hits: `mem_ready` wins, no `err`.
  - `rst` during BUSY: return to IDLE next edge, `mem_req` drops, the counter clears, no `done`.
  - `core_valid` dropping during BUSY violates protocol; the access still completes.

## Timing
- Reset values: state IDLE, counter 0, `done`=0, `err`=0, `load_data`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0. `stall` follows `core_valid`.
- Minimum latency, with `mem_ready` high on the first BUSY cycle: accept at cycle 0, BUSY at 1, `done` at 2.
- Each wait cycle adds one cycle of latency.
- Error from IDLE: `done` at cycle 1.
- `mem_*` outputs are registered and stay stable for the whole of BUSY.
- The next access can be accepted in the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses raise `err` as described above.
  - Half misaligned: `addr[0]`=1.
  - Word misaligned: `addr[1:0]`≠0.
- `LSU_MISALIGN_TRAP_EN` undefined: no misalignment check.
  - Half uses `addr[1]` only.
  - Word ignores `addr[1:0]`.
  - The access proceeds to memory with `err`=0.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF after 2 wait cycles → `mem_be`=1111, `mem_addr`=0x100; `done` at cycle 4 with `load_data`=0xDEADBEEF, `err`=0; `stall` high cycles 0–3.
- Memory word 0x80FF1234 read from addr 0x103:
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - LH at 0x102 → 0xFFFF80FF.
- SH at 0x106 with `wdata`=0x0000ABCD → `mem_we`=1, `mem_be`=1100, `mem_addr`=0x104, `mem_wdata`=0xABCDABCD.
- With `LSU_MISALIGN_TRAP_EN` defined, LW at 0x102 → `done`+`err` at cycle 1, `mem_req` never high. Without the macro → access at 0x100, `err`=0.
- `TIMEOUT_CYCLES`=4, `mem_ready` held low → `done`+`err` after 4 BUSY cycles, `load_data`=0. `funct3`=011 → `err` at cycle 1.
- `rst` asserted in the second BUSY cycle → `mem_req`=0 and IDLE on the next edge, no `done`. A following LW completes normally.
